// File: rtl/mpc_pkg.sv
// ---------------------------------------------------------------------------
// mpc_pkg
// Shared definitions for the FCS-MPC acquisition front end: sequencer state
// encoding, ADC channel indices, sample/frame widths and the MOSI frame
// builder used by the SPI shifter.
// ---------------------------------------------------------------------------
package mpc_pkg;

  localparam int SAMPLE_W   = 8;
  localparam int FRAME_BITS = 16;

  localparam logic [1:0] CH_IL = 2'd0;
  localparam logic [1:0] CH_VC = 2'd1;
  localparam logic [1:0] CH_VG = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_PUBLISH,
    ST_DECIDE
  } seq_state_t;

  // Channel select travels in the upper byte; the lower byte is don't-care
  // while the ADC returns its conversion, so it is sent as zeros.
  function automatic logic [FRAME_BITS-1:0] mosi_frame(input logic [1:0] ch);
    return {6'b0, ch, 8'b0};
  endfunction

endpackage

// File: rtl/mpc_spi_shifter.sv
// ---------------------------------------------------------------------------
// mpc_spi_shifter
// One 16-bit SPI mode-0 transfer per start pulse. SCLK idles low, MOSI
// changes on SCLK falling edges, MISO is sampled on SCLK rising edges.
// A transfer lasts 32*CLK_DIV clocks after the start pulse.
//
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   start      : one-cycle pulse, begins a transfer on the next clock
//   ch         : ADC channel placed in the MOSI frame (sampled with start)
//   miso       : ADC serial data in
//   sclk, mosi : SPI clock and data out
//   done       : high during the final clock of the transfer
//   sample     : low byte of the received frame (valid while done is high)
// ---------------------------------------------------------------------------
module mpc_spi_shifter
  import mpc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          ch,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic                done,
  output logic [SAMPLE_W-1:0] sample
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * FRAME_BITS);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS - 1);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("mpc_spi_shifter: CLK_DIV must be in 1..255");
  end

  logic                  busy;
  logic [DIV_W-1:0]      div_cnt;
  logic [HALF_W-1:0]     half_cnt;
  logic [FRAME_BITS-1:0] tx_sh;
  logic [FRAME_BITS-1:0] rx_sh;
  logic [FRAME_BITS-1:0] frame;
  logic                  half_end;

  assign frame    = mosi_frame(ch);
  assign half_end = busy && (div_cnt == DIV_LAST);
  assign done     = half_end && (half_cnt == HALF_LAST);
  assign sample   = rx_sh[SAMPLE_W-1:0];

  // Each SCLK half-period is CLK_DIV clocks. Even half-periods are the low
  // phase; ending one raises SCLK and samples MISO at that same clock, while
  // the ADC has held the bit stable for the whole low phase. Ending an odd
  // half-period lowers SCLK and advances MOSI. The first MOSI bit is loaded
  // by start itself so it is stable before the first rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      sclk     <= 1'b0;
      div_cnt  <= '0;
      half_cnt <= '0;
      mosi     <= frame[FRAME_BITS-1];
      tx_sh    <= frame << 1;
      rx_sh    <= '0;
    end else if (busy) begin
      if (half_end) begin
        div_cnt  <= '0;
        half_cnt <= half_cnt + 1'b1;
        if (!half_cnt[0]) begin
          sclk  <= 1'b1;
          rx_sh <= {rx_sh[FRAME_BITS-2:0], miso};
        end else begin
          sclk <= 1'b0;
          if (done) begin
            busy <= 1'b0;
            mosi <= 1'b0;
          end else begin
            mosi  <= tx_sh[FRAME_BITS-1];
            tx_sh <= tx_sh << 1;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpc_sample_sequencer.sv
// ---------------------------------------------------------------------------
// mpc_sample_sequencer
// Periodic acquisition of iL / vc / vg from a 3-channel SPI ADC, publication
// of a coherent sample triplet to the MPC, capture of the MPC switch decision
// and complementary gate drive.
//
// Build option: define MPC_DEADTIME_EN to insert DEAD_CYCLES clocks of
// both-off dead time on every gate command change.
//
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   en                 : enables acquisition and gate drive
//   adc_miso/sclk/cs_n/mosi : SPI ADC interface (mode 0)
//   iL, vc, vg         : held samples; sample_valid pulses on update
//   u_in               : MPC switch decision (combinational on samples)
//   gate_hi, gate_lo   : registered complementary gate outputs
//   overrun            : sticky, period tick seen while busy
//   io_oeb             : constant 0
// ---------------------------------------------------------------------------
module mpc_sample_sequencer
  import mpc_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int PERIOD      = 1000,
  parameter int DEAD_CYCLES = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                en,
  input  logic                adc_miso,
  output logic                adc_sclk,
  output logic                adc_cs_n,
  output logic                adc_mosi,
  output logic [SAMPLE_W-1:0] iL,
  output logic [SAMPLE_W-1:0] vc,
  output logic [SAMPLE_W-1:0] vg,
  output logic                sample_valid,
  input  logic                u_in,
  output logic                gate_hi,
  output logic                gate_lo,
  output logic                overrun,
  output logic                io_oeb
);

  localparam int TMR_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);

  if (DEAD_CYCLES < 1 || DEAD_CYCLES > 65535) begin : g_bad_dead_cycles
    $error("mpc_sample_sequencer: DEAD_CYCLES must be in 1..65535");
  end

  seq_state_t          state;
  logic [TMR_W-1:0]    timer;
  logic                tick;
  logic [1:0]          ch;
  logic                spi_start;
  logic                spi_done;
  logic [SAMPLE_W-1:0] spi_sample;
  logic [SAMPLE_W-1:0] sh_il;
  logic [SAMPLE_W-1:0] sh_vc;
  logic [SAMPLE_W-1:0] sh_vg;
  logic                cmd;
  logic                armed;

  assign tick   = (timer == '0);
  assign io_oeb = 1'b0;

  mpc_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .start  (spi_start),
    .ch     (ch),
    .miso   (adc_miso),
    .sclk   (adc_sclk),
    .mosi   (adc_mosi),
    .done   (spi_done),
    .sample (spi_sample)
  );

  // Free-running control-period timer; it keeps counting while disabled so
  // re-enabling lands on the same period grid.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      timer <= '0;
    end else if (timer == TMR_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Acquisition sequencer. Three frames (CS_SETUP, SHIFT, CS_HOLD) fill the
  // shadow registers; the published outputs move together only on the way
  // into PUBLISH. The MPC decision is latched on the way out of PUBLISH so
  // the command is already valid during DECIDE. Dropping en only takes
  // effect at a frame boundary, so CS never releases mid-transfer. The
  // disable force is written last so it wins over a same-cycle decision.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= ST_IDLE;
      ch           <= CH_IL;
      adc_cs_n     <= 1'b1;
      spi_start    <= 1'b0;
      sh_il        <= '0;
      sh_vc        <= '0;
      sh_vg        <= '0;
      iL           <= '0;
      vc           <= '0;
      vg           <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      cmd          <= 1'b0;
      armed        <= 1'b0;
    end else begin
      spi_start    <= 1'b0;
      sample_valid <= 1'b0;
      if (tick && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (tick && en) begin
            state     <= ST_CS_SETUP;
            ch        <= CH_IL;
            adc_cs_n  <= 1'b0;
            spi_start <= 1'b1;
          end
        end
        ST_CS_SETUP: begin
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (spi_done) begin
            state    <= ST_CS_HOLD;
            adc_cs_n <= 1'b1;
            case (ch)
              CH_IL:   sh_il <= spi_sample;
              CH_VC:   sh_vc <= spi_sample;
              default: sh_vg <= spi_sample;
            endcase
          end
        end
        ST_CS_HOLD: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (ch == CH_VG) begin
            state        <= ST_PUBLISH;
            iL           <= sh_il;
            vc           <= sh_vc;
            vg           <= sh_vg;
            sample_valid <= 1'b1;
          end else begin
            state     <= ST_CS_SETUP;
            ch        <= ch + 2'd1;
            adc_cs_n  <= 1'b0;
            spi_start <= 1'b1;
          end
        end
        ST_PUBLISH: begin
          state <= ST_DECIDE;
          cmd   <= u_in;
          armed <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (!en) begin
        cmd   <= 1'b0;
        armed <= 1'b1;
      end
    end
  end

`ifdef MPC_DEADTIME_EN
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);

  logic [15:0] dead_cnt;
  logic        dead_tgt;

  // Break-before-make gate drive. A wrong-side active output is dropped at
  // once; with both off the counter runs DEAD_CYCLES clocks toward dead_tgt
  // and restarts whenever the command moves again, so the side that finally
  // turns on always matches the latest command.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gate_hi  <= 1'b0;
      gate_lo  <= 1'b0;
      dead_cnt <= '0;
      dead_tgt <= 1'b0;
    end else if (armed) begin
      if (cmd ? gate_hi : gate_lo) begin
        dead_cnt <= '0;
      end else if (gate_hi || gate_lo) begin
        gate_hi  <= 1'b0;
        gate_lo  <= 1'b0;
        dead_tgt <= cmd;
        dead_cnt <= '0;
      end else if (dead_tgt != cmd) begin
        dead_tgt <= cmd;
        dead_cnt <= '0;
      end else if (dead_cnt >= DEAD_LAST) begin
        gate_hi  <= cmd;
        gate_lo  <= ~cmd;
        dead_cnt <= '0;
      end else begin
        dead_cnt <= dead_cnt + 16'd1;
      end
    end
  end
`else
  // Complementary drive switching in the same clock. Until the first
  // decision or disable force arrives, both sides stay off.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gate_hi <= 1'b0;
      gate_lo <= 1'b0;
    end else if (armed) begin
      gate_hi <= cmd;
      gate_lo <= ~cmd;
    end
  end
`endif

endmodule

// File: tb/tb_mpc_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mpc_sample_sequencer
// Scoreboard bench: expected triplets and publish cycles are queued with the
// stimulus; monitors pop and compare on each sample_valid. A second instance
// with a short period exercises the overrun path.
// ---------------------------------------------------------------------------
module tb_mpc_sample_sequencer;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic       en, en_ovr;
  logic       adc_miso = 1'b0;
  logic       u_in;
  logic       adc_sclk, adc_cs_n, adc_mosi;
  logic [7:0] iL, vc, vg;
  logic       sample_valid, gate_hi, gate_lo, overrun, io_oeb;

  logic       ovr_sclk, ovr_cs_n, ovr_mosi;
  logic [7:0] ovr_il, ovr_vc, ovr_vg;
  logic       ovr_valid, ovr_hi, ovr_lo, ovr_overrun, ovr_oeb;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tick_cyc = 0;

  typedef struct {
    logic [7:0] il;
    logic [7:0] vc;
    logic [7:0] vg;
    int         at;
  } triplet_t;

  triplet_t   sb_q[$];
  int         ovr_q[$];
  logic [7:0] chan_q[$];
  triplet_t   exp_t;
  int         exp_c;

  mpc_sample_sequencer #(.CLK_DIV(4), .PERIOD(1000), .DEAD_CYCLES(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .en(en), .adc_miso(adc_miso),
    .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_mosi(adc_mosi),
    .iL(iL), .vc(vc), .vg(vg), .sample_valid(sample_valid), .u_in(u_in),
    .gate_hi(gate_hi), .gate_lo(gate_lo), .overrun(overrun), .io_oeb(io_oeb)
  );

  mpc_sample_sequencer #(.CLK_DIV(4), .PERIOD(300), .DEAD_CYCLES(8)) dut_ovr (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .en(en_ovr), .adc_miso(1'b0),
    .adc_sclk(ovr_sclk), .adc_cs_n(ovr_cs_n), .adc_mosi(ovr_mosi),
    .iL(ovr_il), .vc(ovr_vc), .vg(ovr_vg), .sample_valid(ovr_valid), .u_in(1'b0),
    .gate_hi(ovr_hi), .gate_lo(ovr_lo), .overrun(ovr_overrun), .io_oeb(ovr_oeb)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // ADC model: mode-0 slave. Bits 15..8 return zero while the channel byte
  // arrives on MOSI; bits 7..0 return the value set for that channel.
  logic [7:0]  adc_val [4];
  logic [15:0] mosi_sh;
  logic [7:0]  resp;
  int          sclk_edges;

  always @(negedge adc_cs_n) begin
    sclk_edges = 0;
    adc_miso   = 1'b0;
  end

  always @(posedge adc_sclk) begin
    mosi_sh = {mosi_sh[14:0], adc_mosi};
    sclk_edges++;
    if (sclk_edges == 8) begin
      chan_q.push_back(mosi_sh[7:0]);
      resp = adc_val[mosi_sh[1:0]];
    end
  end

  always @(negedge adc_sclk) begin
    if (!adc_cs_n && sclk_edges >= 8 && sclk_edges < 16) begin
      adc_miso = resp[7];
      resp     = resp << 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc - tick_cyc);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic u,
                               input int publish_at);
    triplet_t t;
    adc_val[0] = a;
    adc_val[1] = b;
    adc_val[2] = c;
    adc_val[3] = 8'h00;
    u_in = u;
    if (publish_at >= 0) begin
      t.il = a; t.vc = b; t.vg = c; t.at = publish_at;
      sb_q.push_back(t);
    end
  endtask

  // Moves to the negedge of the cycle at offset from the first tick.
  task automatic at(input int offset);
    if (cyc > tick_cyc + offset) begin
      miscompares++;
      $display("[TB] FAIL schedule: at cycle %0d, required %0d", cyc - tick_cyc, offset);
    end
    while (cyc < tick_cyc + offset) @(negedge wb_clk_i);
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge wb_clk_i) begin
    if (sample_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_valid: got sample_valid=1 at cycle %0d, expected 0",
                 cyc - tick_cyc);
      end else begin
        exp_t = sb_q.pop_front();
        checkOutput("publish_cycle", 32'(cyc), 32'(exp_t.at));
        checkOutput("iL", 32'(iL), 32'(exp_t.il));
        checkOutput("vc", 32'(vc), 32'(exp_t.vc));
        checkOutput("vg", 32'(vg), 32'(exp_t.vg));
      end
    end
  end

  // Publish-cycle monitor for the overrun instance.
  always @(negedge wb_clk_i) begin
    if (ovr_valid === 1'b1) begin
      if (ovr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL ovr_unexpected_valid: got 1 at cycle %0d, expected 0",
                 cyc - tick_cyc);
      end else begin
        exp_c = ovr_q.pop_front();
        checkOutput("ovr_publish_cycle", 32'(cyc), 32'(exp_c));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wb_rst_i = 1'b1;
    en = 1'b0;
    en_ovr = 1'b0;
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, -1);
    repeat (4) @(negedge wb_clk_i);

    checkOutput("rst_cs_n", 32'(adc_cs_n), 32'd1);
    checkOutput("rst_sclk", 32'(adc_sclk), 32'd0);
    checkOutput("rst_mosi", 32'(adc_mosi), 32'd0);
    checkOutput("rst_samples", {8'h0, iL, vc, vg}, 32'd0);
    checkOutput("rst_valid", 32'(sample_valid), 32'd0);
    checkOutput("rst_gates", {30'd0, gate_hi, gate_lo}, 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_io_oeb", 32'(io_oeb), 32'd0);

    // Period 1: the cycle in which reset drops is the first tick.
    en = 1'b1;
    en_ovr = 1'b1;
    wb_rst_i = 1'b0;
    tick_cyc = cyc;
    applyStimulus(8'h3A, 8'h7F, 8'hC5, 1'b1, tick_cyc + 391);
    ovr_q.push_back(tick_cyc + 391);
    ovr_q.push_back(tick_cyc + 991);

    at(300);  checkOutput("ovr_overrun_pre", 32'(ovr_overrun), 32'd0);
    at(301);  checkOutput("ovr_overrun_set", 32'(ovr_overrun), 32'd1);
    at(390);  checkOutput("iL_before_publish", 32'(iL), 32'd0);
    at(392);  checkOutput("gates_unarmed", {30'd0, gate_hi, gate_lo}, 32'd0);
`ifdef MPC_DEADTIME_EN
    at(400);  checkOutput("dt_first_hi_wait", 32'(gate_hi), 32'd0);
    at(401);  checkOutput("dt_first_hi", {30'd0, gate_hi, gate_lo}, 32'b10);
`else
    at(393);  checkOutput("first_gate_hi", {30'd0, gate_hi, gate_lo}, 32'b10);
    at(400);
`endif
    checkOutput("mosi_frames", 32'(chan_q.size()), 32'd3);
    if (chan_q.size() >= 3) begin
      checkOutput("mosi_ch0", 32'(chan_q[0]), 32'h00);
      checkOutput("mosi_ch1", 32'(chan_q[1]), 32'h01);
      checkOutput("mosi_ch2", 32'(chan_q[2]), 32'h02);
    end

    // Period 2: decision flips to 0.
    at(600);  applyStimulus(8'h11, 8'h22, 8'h33, 1'b0, tick_cyc + 1391);
    at(1000); en_ovr = 1'b0;
    at(1390); checkOutput("iL_held", 32'(iL), 32'h3A);
`ifdef MPC_DEADTIME_EN
    at(1393); checkOutput("dt_hi_drop", {30'd0, gate_hi, gate_lo}, 32'b00);
    at(1400); checkOutput("dt_lo_wait", {30'd0, gate_hi, gate_lo}, 32'b00);
    at(1401); checkOutput("dt_lo_on", {30'd0, gate_hi, gate_lo}, 32'b01);
`else
    at(1392); checkOutput("gate_hold_hi", {30'd0, gate_hi, gate_lo}, 32'b10);
    at(1393); checkOutput("gate_swap_lo", {30'd0, gate_hi, gate_lo}, 32'b01);
`endif

    // Period 3: full-scale / zero / mid samples, decision back to 1.
    at(1600); applyStimulus(8'hFF, 8'h00, 8'h80, 1'b1, tick_cyc + 2391);
    at(2392); checkOutput("gate_hold_lo", {30'd0, gate_hi, gate_lo}, 32'b01);
`ifdef MPC_DEADTIME_EN
    at(2393); checkOutput("dt_lo_drop", {30'd0, gate_hi, gate_lo}, 32'b00);
    at(2400); checkOutput("dt_hi_wait", {30'd0, gate_hi, gate_lo}, 32'b00);
    at(2401); checkOutput("dt_hi_on", {30'd0, gate_hi, gate_lo}, 32'b10);
`else
    at(2393); checkOutput("gate_swap_hi", {30'd0, gate_hi, gate_lo}, 32'b10);
`endif

    // Period 4: disable during channel 1; nothing may publish.
    at(2600); applyStimulus(8'h55, 8'h66, 8'h77, 1'b1, -1);
    at(3150); en = 1'b0;
    at(3170); checkOutput("disable_gates", {30'd0, gate_hi, gate_lo}, 32'b01);
    at(3259); checkOutput("disable_cs_active", 32'(adc_cs_n), 32'd0);
    at(3260); checkOutput("disable_cs_release", 32'(adc_cs_n), 32'd1);
    at(3300); checkOutput("disable_idle_bus", {30'd0, adc_cs_n, adc_sclk}, 32'b10);
    at(3500); checkOutput("disable_samples_held", {8'h0, iL, vc, vg}, 32'h00FF0080);

    // Period 5: reset in the middle of the channel-0 shift.
    at(3600); en = 1'b1;
    at(4050); checkOutput("midframe_cs", 32'(adc_cs_n), 32'd0);
    wb_rst_i = 1'b1;
    en = 1'b0;
    at(4051);
    checkOutput("abort_bus", {30'd0, adc_cs_n, adc_sclk}, 32'b10);
    checkOutput("abort_samples", {8'h0, iL, vc, vg}, 32'd0);
    checkOutput("abort_gates", {30'd0, gate_hi, gate_lo}, 32'd0);
    checkOutput("abort_ovr_flag", 32'(ovr_overrun), 32'd0);
    at(4060); wb_rst_i = 1'b0;

    at(4100);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
    checkOutput("ovr_sb_drained", 32'(ovr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mpc_sample_sequencer.md
# mpc_sample_sequencer

Acquisition and actuation front end for the combinational FCS-MPC boost-converter controller. Once per control period it reads inductor current, capacitor voltage and grid/input voltage from an external 3-channel SPI ADC. It presents the three 8-bit samples to the MPC as one coherent, held triplet. One cycle later it captures the MPC's switch decision and drives complementary gate outputs to the power stage.

## Interface
- `CLK_DIV`, 4: SCLK half-period in `wb_clk_i` cycles; legal range 1–255.
- `PERIOD`, 1000: control period in clocks. Must exceed `3*(2+32*CLK_DIV)+2`.
- `DEAD_CYCLES`, 8: dead-time length in clocks. Used only with `MPC_DEADTIME_EN`.
- `wb_clk_i` in 1: single system clock.
- `wb_rst_i` in 1: synchronous, active-high reset.
- `en` in 1: enables periodic acquisition and gate drive.
- `adc_miso` in 1: ADC serial data.
- `adc_sclk` out 1: SPI clock, mode 0, idle low.
- `adc_cs_n` out 1: ADC chip select, active low.
- `adc_mosi` out 1: channel-select serial data.
- `iL` out 8: held inductor-current sample.
- `vc` out 8: held capacitor-voltage sample.
- `vg` out 8: held input-voltage sample.
- `sample_valid` out 1: one-cycle pulse when a new triplet is published.
- `u_in` in 1: switch decision from the MPC. It is combinational on `iL`/`vc`/`vg`.
- `gate_hi` out 1: main switch drive.
- `gate_lo` out 1: complementary switch drive.
- `overrun` out 1: sticky flag, set when a period tick arrives mid-acquisition. Cleared only by reset.
- `io_oeb` out 1: constant 0.

## Operation
- **Period timer.** Counts 0..`PERIOD-1` and wraps. A tick occurs at count 0. The timer runs regardless of `en`.
- **FSM states.** IDLE → CS_SETUP → SHIFT → CS_HOLD → (next channel: CS_SETUP | last: PUBLISH) → DECIDE → IDLE.
- **IDLE.** Leaves on a tick when `en`=1.
- **CS_SETUP.** Lasts 1 clock with `adc_cs_n`=0 and SCLK low.
- **SHIFT.** Runs 16 SCLK periods, MSB first.
  - MOSI frame bits 15..8 = `{6'b0, ch[1:0]}`; bits 7..0 = 0.
  - MOSI changes on SCLK falling edges. The first bit is valid at the CS_SETUP exit.
  - MISO is sampled on SCLK rising edges. Frame bits 7..0 are the sample; bits 15..8 are discarded.
- **CS_HOLD.** Lasts 1 clock with `adc_cs_n`=1.
- **Channel order.** 0 → `iL`, 1 → `vc`, 2 → `vg`. Samples go into shadow registers.
- **PUBLISH.** Copies all three shadow registers to the outputs in the same clock and pulses `sample_valid`. Outputs otherwise hold.
- **DECIDE.** The clock after PUBLISH. Registers `u_in` as the new gate command.
- **Gate command.** `gate_hi` = command. `gate_lo` = ~command, subject to the dead-time rule in Configuration.
- **Period tick while not IDLE.** Sets `overrun`. That tick is ignored; there is no queued acquisition.
- **`en` deasserted mid-acquisition.**
  - The current frame completes and `adc_cs_n` returns high cleanly.
  - The FSM returns to IDLE without PUBLISH. Published samples keep their old values.
- **`en`=0.** The gate command is forced to 0: `gate_hi`=0 and `gate_lo`=1.

## Timing
- **Reset values.** All of the following are 0: `adc_sclk`, `adc_mosi`, `iL`, `vc`, `vg`, `sample_valid`, `gate_hi`, `gate_lo`, `overrun`, `io_oeb`. `adc_cs_n`=1. FSM is in IDLE, timer = 0. Reset mid-frame aborts the frame immediately.
- **Frame length.** `2+32*CLK_DIV` clocks. This is 130 at the default.
- **Tick to `sample_valid`.** `3*(2+32*CLK_DIV)+1` clocks. This is 391 at the default.
- **`sample_valid` to gate update.** 2 clocks: DECIDE register, then the output register.
- **Gate outputs.** Registered, glitch-free, and never both 1.

## Configuration
- **`MPC_DEADTIME_EN` defined.**
  - On any command change, the currently active output drops first.
  - Both outputs stay 0 for `DEAD_CYCLES` clocks, then the new output asserts.
  - A command change during dead-time restarts the count toward the latest command.
- **Undefined.**
  - `gate_lo` = ~`gate_hi`, changing in the same clock.
  - Exception: after reset, both outputs stay 0 until the first DECIDE or an `en`=0 force.
  - `DEAD_CYCLES` is unused.

## Structure
- **Shared package `mpc_pkg`.** Holds:
  - the FSM state enum;
  - channel index constants `CH_IL`=0, `CH_VC`=1, `CH_VG`=2;
  - `SAMPLE_W`=8;
  - `FRAME_BITS`=16.
- **Sub-module `mpc_spi_shifter`.** Owns SCLK division, the 16-bit MOSI/MISO shift, and start/done handshakes. The top level holds the timer, FSM, sample registers and gate/dead-time logic.

## Test plan
- **Basic acquisition.** ADC model returns 0x3A/0x7F/0xC5 for ch0/1/2 with `en`=1 → at clock 391 after the tick, `iL`=0x3A, `vc`=0x7F, `vg`=0xC5 all change together with a 1-cycle `sample_valid`. Captured MOSI channel bytes are 0x00, 0x01, 0x02.
- **Decision capture.** `u_in`=1 at DECIDE → `gate_hi`=1 two clocks after `sample_valid`. Next period `u_in`=0 → `gate_hi` falls and `gate_lo` rises in the same clock (macro off).
- **Dead-time.** With `MPC_DEADTIME_EN` and `DEAD_CYCLES`=8, a 0→1 command → `gate_lo` drops, both outputs are 0 for exactly 8 clocks, then `gate_hi`=1.
- **Overrun.** `PERIOD`=300 with `CLK_DIV`=4 → `overrun`=1 after the first mid-acquisition tick. The next `sample_valid` arrives only after the following tick that finds the FSM in IDLE.
- **Disable mid-acquisition.** Drop `en` during channel 1 → frame completes, `adc_cs_n` goes high, no `sample_valid`, samples unchanged, `gate_hi`=0, `gate_lo`=1.
- **Reset mid-frame.** Assert `wb_rst_i` mid-SHIFT → next clock `adc_cs_n`=1, SCLK=0, all samples, gates and flags 0.
